axis_pipe_slice: RTL and testbench

Parametrised AXI4-Stream pipeline slice for timing closure between stream blocks. It chains STAGES identical slices. Each slice is built in one of four register modes (full, forward, reverse, bypass). Every mode preserves AXI4-Stream ordering and handshake rules, with no bubbles at full throughput. Optional per-instance beat and packet counters support debug.

---
 rtl/axis_pipe_slice_if.sv | 27 ++
 rtl/axis_pipe_slice.sv | 245 ++++++++++++++++++++++++
 tb/tb_axis_pipe_slice.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pipe_slice_if.sv
// AXI4-Stream bundle for axis_pipe_slice.
// master drives the payload and valid; slave drives ready.
interface axis_pipe_slice_if #(
    parameter int unsigned N = 4,
    parameter int unsigned I = 1,
    parameter int unsigned D = 1,
    parameter int unsigned U = 1
);
    logic           tvalid;
    logic           tready;
    logic [8*N-1:0] tdata;
    logic [N-1:0]   tkeep;
    logic           tlast;
    logic [I-1:0]   tid;
    logic [D-1:0]   tdest;
    logic [U-1:0]   tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_pipe_slice.sv
// axis_pipe_slice: chain of STAGES AXI4-Stream register slices.
// MODE 0 full (main + skid), 1 forward (valid/data registered),
// 2 reverse (registered ready with skid), 3 bypass (wires only).
// Define AXIS_PIPE_SLICE_STATS_EN to add beat_count / pkt_count outputs.
module axis_pipe_slice #(
    parameter int unsigned N         = 4,
    parameter int unsigned USE_TKEEP = 1,
    parameter int unsigned I         = 1,
    parameter int unsigned D         = 1,
    parameter int unsigned U         = 1,
    parameter int unsigned MODE      = 0,
    parameter int unsigned STAGES    = 1
) (
    input logic              aclk,
    input logic              aresetn,
    axis_pipe_slice_if.slave  s,
    axis_pipe_slice_if.master m
`ifdef AXIS_PIPE_SLICE_STATS_EN
    ,
    output logic [31:0]      beat_count,
    output logic [31:0]      pkt_count
`endif
);

    if (N < 1 || N > 128) begin : g_bad_n
        $fatal(1, "axis_pipe_slice: N=%0d outside 1..128", N);
    end
    if (USE_TKEEP > 1) begin : g_bad_keep
        $fatal(1, "axis_pipe_slice: USE_TKEEP=%0d must be 0 or 1", USE_TKEEP);
    end
    if (I < 1 || I > 8) begin : g_bad_i
        $fatal(1, "axis_pipe_slice: I=%0d outside 1..8", I);
    end
    if (D < 1 || D > 8) begin : g_bad_d
        $fatal(1, "axis_pipe_slice: D=%0d outside 1..8", D);
    end
    if (U < 1 || U > 64) begin : g_bad_u
        $fatal(1, "axis_pipe_slice: U=%0d outside 1..64", U);
    end
    if (MODE > 3) begin : g_bad_mode
        $fatal(1, "axis_pipe_slice: MODE=%0d outside 0..3", MODE);
    end
    if (MODE != 3 && (STAGES < 1 || STAGES > 8)) begin : g_bad_stages
        $fatal(1, "axis_pipe_slice: STAGES=%0d outside 1..8", STAGES);
    end

    localparam int unsigned KW = (USE_TKEEP != 0) ? N : 0;
    localparam int unsigned W  = 8 * N + KW + I + D + U + 1;
    // Bypass has no state, so a single pass-through link is enough.
    localparam int unsigned NS = (MODE == 3) ? 1 : STAGES;

    logic [W-1:0] s_word;
    logic [W-1:0] m_word;

    // Link k sits in front of stage k; link NS is the output.
    logic [NS:0]  vld;
    logic [NS:0]  rdy;
    logic [W-1:0] dat [NS+1];

    if (USE_TKEEP != 0) begin : g_keep
        assign s_word = {s.tdata, s.tkeep, s.tlast, s.tid, s.tdest, s.tuser};
        assign {m.tdata, m.tkeep, m.tlast, m.tid, m.tdest, m.tuser} = m_word;
    end else begin : g_nokeep
        logic unused_tkeep;
        assign unused_tkeep = ^s.tkeep;
        assign s_word = {s.tdata, s.tlast, s.tid, s.tdest, s.tuser};
        assign {m.tdata, m.tlast, m.tid, m.tdest, m.tuser} = m_word;
        assign m.tkeep = '1;
    end

    assign vld[0]   = s.tvalid;
    assign dat[0]   = s_word;
    assign s.tready = rdy[0];
    assign m.tvalid = vld[NS];
    assign m_word   = dat[NS];
    assign rdy[NS]  = m.tready;

    for (genvar k = 0; k < NS; k++) begin : g_stage
        if (MODE == 0) begin : g_full
            typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;
            state_e       state_q;
            logic         valid_q;
            logic         ready_q;
            logic [W-1:0] main_q;
            logic [W-1:0] skid_q;
            logic         in_xfer;
            logic         out_xfer;
            logic         load_main;
            logic         load_skid;

            assign in_xfer  = vld[k] & ready_q;
            assign out_xfer = valid_q & rdy[k+1];
            assign vld[k+1] = valid_q;
            assign dat[k+1] = main_q;
            assign rdy[k]   = ready_q;

            // Payload load enables: main takes the input or the skid word, skid takes input.
            always_comb begin
                load_main = 1'b0;
                load_skid = 1'b0;
                unique case (state_q)
                    StEmpty: load_main = in_xfer;
                    StOne: begin
                        load_main = in_xfer & out_xfer;
                        load_skid = in_xfer & ~out_xfer;
                    end
                    StTwo:   load_main = out_xfer;
                    default: ;
                endcase
            end

            // Occupancy FSM with registered valid and ready.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    state_q <= StEmpty;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                end else begin
                    ready_q <= 1'b1;
                    unique case (state_q)
                        StEmpty: begin
                            if (in_xfer) begin
                                state_q <= StOne;
                                valid_q <= 1'b1;
                            end
                        end
                        StOne: begin
                            if (in_xfer && !out_xfer) begin
                                state_q <= StTwo;
                                ready_q <= 1'b0;
                            end else if (!in_xfer && out_xfer) begin
                                state_q <= StEmpty;
                                valid_q <= 1'b0;
                            end
                        end
                        StTwo: begin
                            if (out_xfer) begin
                                state_q <= StOne;
                            end else begin
                                ready_q <= 1'b0;
                            end
                        end
                        default: begin
                            state_q <= StEmpty;
                            valid_q <= 1'b0;
                        end
                    endcase
                end
            end

            // Payload storage; never reset, qualified by the valid state.
            always_ff @(posedge aclk) begin
                if (load_main) begin
                    main_q <= (state_q == StTwo) ? skid_q : dat[k];
                end
                if (load_skid) begin
                    skid_q <= dat[k];
                end
            end
        end else if (MODE == 1) begin : g_fwd
            logic         valid_q;
            logic         init_q;
            logic [W-1:0] data_q;

            // init_q holds ready low in reset and until the first edge after release.
            assign rdy[k]   = init_q & (~valid_q | rdy[k+1]);
            assign vld[k+1] = valid_q;
            assign dat[k+1] = data_q;

            // Valid register; reloads whenever the stage can accept.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    valid_q <= 1'b0;
                    init_q  <= 1'b0;
                end else begin
                    init_q <= 1'b1;
                    if (rdy[k]) begin
                        valid_q <= vld[k];
                    end
                end
            end

            // Payload register, loaded on input transfer.
            always_ff @(posedge aclk) begin
                if (rdy[k] && vld[k]) begin
                    data_q <= dat[k];
                end
            end
        end else if (MODE == 2) begin : g_rev
            logic         skid_full_q;
            logic         skid_full_d;
            logic         ready_q;
            logic [W-1:0] skid_q;
            logic         capture;

            assign rdy[k]   = ready_q;
            assign vld[k+1] = skid_full_q | (vld[k] & ready_q);
            assign dat[k+1] = skid_full_q ? skid_q : dat[k];
            assign capture  = vld[k] & ready_q & ~rdy[k+1];

            // Skid fills on a stalled input transfer and empties when downstream takes it.
            always_comb begin
                skid_full_d = skid_full_q ? ~rdy[k+1] : capture;
            end

            // Skid flag and registered ready.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    skid_full_q <= 1'b0;
                    ready_q     <= 1'b0;
                end else begin
                    skid_full_q <= skid_full_d;
                    ready_q     <= ~skid_full_d;
                end
            end

            // Skid payload.
            always_ff @(posedge aclk) begin
                if (capture) begin
                    skid_q <= dat[k];
                end
            end
        end else begin : g_byp
            assign vld[k+1] = vld[k];
            assign dat[k+1] = dat[k];
            assign rdy[k]   = rdy[k+1];
        end
    end

`ifdef AXIS_PIPE_SLICE_STATS_EN
    // Debug counters on output transfers; wrap naturally at 2^32.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_count <= 32'd0;
            pkt_count  <= 32'd0;
        end else if (m.tvalid && m.tready) begin
            beat_count <= beat_count + 32'd1;
            if (m.tlast) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_pipe_slice.sv
// Bench for axis_pipe_slice: several configurations share one stimulus stream;
// a scoreboard queue of accepted beats is checked against the selected instance.
`timescale 1ns/1ps
module tb_axis_pipe_slice;
    localparam int unsigned N        = 4;
    localparam int unsigned I        = 2;
    localparam int unsigned D        = 3;
    localparam int unsigned U        = 5;
    localparam int unsigned WW       = 8 * N + N + 1 + I + D + U;
    localparam int unsigned LAST_BIT = U + D + I;
    localparam int          NDUT     = 6;
    localparam int unsigned MODES [NDUT] = '{0, 0, 1, 2, 3, 1};
    localparam int unsigned STG   [NDUT] = '{1, 2, 3, 1, 1, 1};
    localparam int unsigned KEEP  [NDUT] = '{1, 1, 1, 1, 1, 0};

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic s_tvalid = 1'b0;
    logic m_tready = 1'b0;
    logic [8*N-1:0] s_tdata = '0;
    logic [N-1:0]   s_tkeep = '0;
    logic           s_tlast = 1'b0;
    logic [I-1:0]   s_tid = '0;
    logic [D-1:0]   s_tdest = '0;
    logic [U-1:0]   s_tuser = '0;

    logic          o_sready [NDUT];
    logic          o_mvalid [NDUT];
    logic [WW-1:0] o_word   [NDUT];
`ifdef AXIS_PIPE_SLICE_STATS_EN
    logic [31:0]   o_beats  [NDUT];
    logic [31:0]   o_pkts   [NDUT];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        axis_pipe_slice_if #(.N(N), .I(I), .D(D), .U(U)) s_if ();
        axis_pipe_slice_if #(.N(N), .I(I), .D(D), .U(U)) m_if ();
        assign s_if.tvalid = s_tvalid;
        assign s_if.tdata  = s_tdata;
        assign s_if.tkeep  = s_tkeep;
        assign s_if.tlast  = s_tlast;
        assign s_if.tid    = s_tid;
        assign s_if.tdest  = s_tdest;
        assign s_if.tuser  = s_tuser;
        assign m_if.tready = m_tready;
        assign o_sready[g] = s_if.tready;
        assign o_mvalid[g] = m_if.tvalid;
        assign o_word[g]   = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser};

        axis_pipe_slice #(
            .N         (N),
            .USE_TKEEP (KEEP[g]),
            .I         (I),
            .D         (D),
            .U         (U),
            .MODE      (MODES[g]),
            .STAGES    (STG[g])
        ) u_dut (
            .aclk       (clk),
            .aresetn    (aresetn),
            .s          (s_if),
            .m          (m_if)
`ifdef AXIS_PIPE_SLICE_STATS_EN
            ,
            .beat_count (o_beats[g]),
            .pkt_count  (o_pkts[g])
`endif
        );
    end

    int            sel = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    int            held_before = 0;
    int            idx = 0;
    logic [WW-1:0] exp_q [$];
    logic [31:0]   got [$];
    logic          last_sr = 1'b0;
    logic          last_mv = 1'b0;
    logic          last_in_x = 1'b0;
    logic          last_out_x = 1'b0;
    logic [WW-1:0] last_word = '0;
    logic          stall_prev = 1'b0;
    logic [WW-1:0] stall_word = '0;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Beat as it should appear downstream: tkeep reads all-ones when not carried.
    function automatic logic [WW-1:0] in_word();
        logic [N-1:0] k;
        k = (KEEP[sel] != 0) ? s_tkeep : '1;
        return {s_tdata, k, s_tlast, s_tid, s_tdest, s_tuser};
    endfunction

    // Words the selected configuration may hold between acceptance and delivery.
    function automatic int cap();
        case (MODES[sel])
            0:       return 2 * int'(STG[sel]);
            1, 2:    return int'(STG[sel]);
            default: return 0;
        endcase
    endfunction

    task automatic monitor();
        logic [WW-1:0] iw;
        last_sr     = o_sready[sel];
        last_mv     = o_mvalid[sel];
        last_word   = o_word[sel];
        held_before = exp_q.size();
        last_in_x   = 1'b0;
        last_out_x  = 1'b0;
        if (!aresetn) begin
            chk("rst_mvalid", last_mv, 0);
            chk("rst_sready", last_sr, 0);
            exp_q.delete();
            stall_prev = 1'b0;
            return;
        end
        if (stall_prev) begin
            chk("hold_valid", last_mv, 1);
            chk("hold_word", last_word, stall_word);
        end
        chk("occupancy", held_before <= cap(), 1);
        iw = in_word();
        if (MODES[sel] == 3) begin
            chk("byp_valid", last_mv, s_tvalid);
            chk("byp_ready", last_sr, m_tready);
            chk("byp_word", last_word, iw);
        end
        last_in_x  = s_tvalid && last_sr;
        last_out_x = last_mv && m_tready;
        if (last_in_x) exp_q.push_back(iw);
        if (last_out_x) begin
            chk("beat_present", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("beat_word", last_word, exp_q.pop_front());
        end
        stall_prev = last_mv && !m_tready;
        stall_word = last_word;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int s);
        sel      = s;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        aresetn  = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
        chk("rel_sready", last_sr, 0);
    endtask

    task automatic new_beat(input logic [31:0] d, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tkeep  = N'($urandom);
        s_tid    = I'($urandom);
        s_tdest  = D'($urandom);
        s_tuser  = U'($urandom);
    endtask

    task automatic run_random(input int cycles, input int pv, input int pr);
        for (int c = 0; c < cycles; c++) begin
            if (!s_tvalid || last_in_x) begin
                if ($urandom_range(99) < pv) new_beat($urandom, 1'($urandom));
                else s_tvalid = 1'b0;
            end
            m_tready = ($urandom_range(99) < pr);
            tick();
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 64 && (s_tvalid || exp_q.size() != 0); c++) begin
            if (last_in_x) s_tvalid = 1'b0;
            m_tready = 1'b1;
            tick();
        end
        if (last_in_x) s_tvalid = 1'b0;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full slice, one stage: 16 back-to-back beats, latency 1, no stalls.
        do_reset(0);
        for (int i = 0; i < 18; i++) begin
            if (i < 16) new_beat(32'(i), i == 15);
            else s_tvalid = 1'b0;
            m_tready = 1'b1;
            tick();
            if (i < 16) chk("t1_sready", last_sr, 1);
            chk("t1_mvalid", last_mv, (i >= 1 && i <= 16));
            if (i >= 1 && i <= 16) chk("t1_data", last_word[WW-1 -: 32], 32'(i - 1));
        end

        // Full slice, two stages: fills to 4 words under back-pressure, then drains gap-free.
        do_reset(1);
        idx = 0;
        new_beat(32'hA0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (last_in_x) begin
                idx++;
                if (idx < 8) new_beat(32'hA0 + 32'(idx), idx == 7);
                else s_tvalid = 1'b0;
            end
        end
        chk("t2_accepted", 32'(idx), 4);
        chk("t2_sready_full", last_sr, 0);
        m_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (last_in_x) begin
                idx++;
                if (idx < 8) new_beat(32'hA0 + 32'(idx), idx == 7);
                else s_tvalid = 1'b0;
            end
            chk("t2_out_valid", last_mv, 1);
            chk("t2_out_data", last_word[WW-1 -: 32], 32'hA0 + 32'(k));
        end
        chk("t2_all_in", 32'(idx), 8);
        drain();

        // Reverse slice: ready toggles; ready is low exactly while the skid holds a word.
        do_reset(3);
        idx = 0;
        got.delete();
        new_beat(32'd1, 1'b0);
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            m_tready = (c % 2 == 0);
            tick();
            chk("t3_sready", last_sr, held_before == 0);
            if (c == 0) chk("t3_zero_latency", last_mv, 1);
            if (last_out_x) got.push_back(last_word[WW-1 -: 32]);
            if (last_in_x) begin
                idx++;
                if (idx < 8) new_beat(32'(idx + 1), idx == 7);
                else s_tvalid = 1'b0;
            end
        end
        chk("t3_count", got.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < got.size()) chk("t3_order", got[k], 32'(k + 1));
        end
        drain();

        // Forward slice, three stages: reset mid-packet, then a fresh packet with latency 3.
        do_reset(2);
        m_tready = 1'b1;
        idx = 0;
        new_beat(32'h100, 1'b0);
        for (int c = 0; c < 10 && idx < 3; c++) begin
            tick();
            if (last_in_x) begin
                idx++;
                new_beat(32'h100 + 32'(idx), idx == 5);
            end
        end
        chk("t4_pre_mvalid", o_mvalid[2], 1);
        aresetn = 1'b0;
        #1;
        chk("t4_rst_mvalid", o_mvalid[2], 0);
        chk("t4_rst_sready", o_sready[2], 0);
        do_reset(2);
        m_tready = 1'b1;
        new_beat(32'h200, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t4_mvalid", last_mv, (i == 3 || i == 4));
            if (i == 3) chk("t4_first", last_word[WW-1 -: 32], 32'h200);
            if (i == 4) begin
                chk("t4_second", last_word[WW-1 -: 32], 32'h201);
                chk("t4_tlast", last_word[LAST_BIT], 1);
            end
            if (last_in_x) begin
                if (i == 0) new_beat(32'h201, 1'b1);
                else s_tvalid = 1'b0;
            end
        end

        // Bypass: outputs mirror inputs every cycle.
        do_reset(4);
        run_random(100, 60, 60);
        drain();

        // Randomised traffic on every registered configuration.
        for (int s = 0; s < NDUT; s++) begin
            if (MODES[s] != 3) begin
                do_reset(s);
                run_random(200, 70, 50);
                run_random(150, 95, 25);
                run_random(150, 95, 95);
                drain();
            end
        end

`ifdef AXIS_PIPE_SLICE_STATS_EN
        // Counters: three 5-beat packets, then reset clears them.
        do_reset(0);
        m_tready = 1'b1;
        idx = 0;
        new_beat(32'd0, 1'b0);
        for (int c = 0; c < 40 && idx < 15; c++) begin
            tick();
            if (last_in_x) begin
                idx++;
                if (idx < 15) new_beat(32'(idx), (idx % 5) == 4);
                else s_tvalid = 1'b0;
            end
        end
        drain();
        chk("beat_count", o_beats[0], 15);
        chk("pkt_count", o_pkts[0], 3);
        aresetn = 1'b0;
        #1;
        chk("beat_count_rst", o_beats[0], 0);
        chk("pkt_count_rst", o_pkts[0], 0);
        do_reset(0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
